// File: rtl/dma_rx_collector.sv
// DMA receive collector: packs N complex samples into a frame store for host readout.
// Optional DMA_RX_CHECKSUM_EN adds a per-frame XOR checksum output.
module dma_rx_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 16,
  parameter int FCNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture_en,
  input  logic                  dma_valid,
  input  logic [DATA_WIDTH-1:0] dma_real,
  input  logic [DATA_WIDTH-1:0] dma_imag,
  output logic                  dma_ack,
  input  logic                  rd_en,
  input  logic [$clog2(N)-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_real,
  output logic [DATA_WIDTH-1:0] rd_imag,
  output logic                  rd_valid,
  output logic                  frame_ready,
  output logic                  frame_done,
  input  logic                  frame_release,
  output logic [$clog2(N):0]    sample_count,
  output logic [FCNT_W-1:0]     frame_count,
  output logic                  overrun
`ifdef DMA_RX_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] frame_checksum
`endif
);

  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;
  localparam int DW = DATA_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RECV = 2'd1;
  localparam logic [1:0] FULL = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d;
  logic              rdv_q;
  logic [DW-1:0]     rdr_q, rdi_q;
  logic [2*DW-1:0]   mem_q [N];
  logic              xfer;
  logic              last;

  // ack comes straight from the state flop, never from dma_valid
  assign dma_ack = (state_q == RECV);
  assign xfer    = dma_valid & dma_ack;
  assign last    = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q | (dma_valid & (state_q == FULL));
    case (state_q)
      IDLE: begin
        if (capture_en) state_d = RECV;
      end
      RECV: begin
        if (xfer) begin
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            state_d = FULL;
            done_d  = 1'b1;
            fcnt_d  = fcnt_q + FCNT_W'(1);
          end
        end
      end
      FULL: begin
        if (frame_release) begin
          state_d = capture_en ? RECV : IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // frame store is deliberately not reset
  always_ff @(posedge clk) begin
    if (xfer) mem_q[cnt_q[AW-1:0]] <= {dma_real, dma_imag};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdv_q <= 1'b0;
      rdr_q <= '0;
      rdi_q <= '0;
    end else begin
      rdv_q <= rd_en;
      if (rd_en) {rdr_q, rdi_q} <= mem_q[rd_addr];
    end
  end

`ifdef DMA_RX_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q != RECV && state_d == RECV) csum_d = '0;
    else if (xfer) csum_d = csum_q ^ dma_real ^ dma_imag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign frame_checksum = csum_q;
`endif

  assign frame_ready  = (state_q == FULL);
  assign frame_done   = done_q;
  assign sample_count = cnt_q;
  assign frame_count  = fcnt_q;
  assign overrun      = ovr_q;
  assign rd_valid     = rdv_q;
  assign rd_real      = rdr_q;
  assign rd_imag      = rdi_q;

endmodule

// File: tb/tb_dma_rx_collector.sv
// Scoreboard bench for dma_rx_collector: reads are queued at issue, checked on rd_valid.
// Define DMA_RX_CHECKSUM_EN to also exercise frame_checksum.
module tb_dma_rx_collector;

  logic        clk;
  logic        reset;
  logic        capture_en;
  logic        dma_valid;
  logic [15:0] dma_real;
  logic [15:0] dma_imag;
  logic        dma_ack;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_real;
  logic [15:0] rd_imag;
  logic        rd_valid;
  logic        frame_ready;
  logic        frame_done;
  logic        frame_release;
  logic [4:0]  sample_count;
  logic [7:0]  frame_count;
  logic        overrun;
`ifdef DMA_RX_CHECKSUM_EN
  logic [15:0] frame_checksum;
`endif

  dma_rx_collector #(
    .DATA_WIDTH(16),
    .N(16),
    .FCNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .capture_en(capture_en),
    .dma_valid(dma_valid),
    .dma_real(dma_real),
    .dma_imag(dma_imag),
    .dma_ack(dma_ack),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_real(rd_real),
    .rd_imag(rd_imag),
    .rd_valid(rd_valid),
    .frame_ready(frame_ready),
    .frame_done(frame_done),
    .frame_release(frame_release),
    .sample_count(sample_count),
    .frame_count(frame_count),
    .overrun(overrun)
`ifdef DMA_RX_CHECKSUM_EN
    ,
    .frame_checksum(frame_checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tot_cnt  = 0;
  int pass_cnt = 0;
  int done_cnt = 0;
  logic [31:0] sbq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // monitor: pops the expected read word whenever the DUT presents one
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (rd_valid) begin
      tot_cnt++;
      if (sbq.size() == 0) begin
        $display("FAIL rd_unexpected: got %0h expected none",
                 {rd_real, rd_imag});
      end else begin
        logic [31:0] e;
        e = sbq.pop_front();
        if ({rd_real, rd_imag} === e) pass_cnt++;
        else $display("FAIL rd_data: got %0h expected %0h",
                      {rd_real, rd_imag}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [15:0] r, input logic [15:0] i);
    @(negedge clk);
    dma_valid = 1'b1;
    dma_real  = r;
    dma_imag  = i;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] r,
                    input logic [15:0] i);
    @(negedge clk);
    rd_en   = 1'b1;
    rd_addr = a;
    sbq.push_back({r, i});
  endtask

  task automatic rd_end();
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic release_frame(input logic cap);
    @(negedge clk);
    capture_en    = cap;
    frame_release = 1'b1;
    @(negedge clk);
    frame_release = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    reset         = 1'b0;
    capture_en    = 1'b0;
    dma_valid     = 1'b0;
    dma_real      = '0;
    dma_imag      = '0;
    rd_en         = 1'b0;
    rd_addr       = '0;
    frame_release = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ack", {31'b0, dma_ack}, 32'd0);
    chk("rst_ready", {31'b0, frame_ready}, 32'd0);
    chk("rst_done", {31'b0, frame_done}, 32'd0);
    chk("rst_cnt", {27'b0, sample_count}, 32'd0);
    chk("rst_fcnt", {24'b0, frame_count}, 32'd0);
    chk("rst_rd", {15'b0, rd_valid, rd_real}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    capture_en = 1'b1;

    // frame 1: back-to-back, real=k imag=-k
    for (int k = 0; k < 16; k++) begin
      v = 16'(-k);
      send(16'(k), v);
      if (k == 0 || k == 15) chk("t1_ack", {31'b0, dma_ack}, 32'd1);
    end
    @(negedge clk);
    dma_valid = 1'b0;
    chk("t1_done", {31'b0, frame_done}, 32'd1);
    chk("t1_ready", {31'b0, frame_ready}, 32'd1);
    chk("t1_cnt", {27'b0, sample_count}, 32'd16);
    chk("t1_fcnt", {24'b0, frame_count}, 32'd1);
    chk("t1_ack_off", {31'b0, dma_ack}, 32'd0);
    @(negedge clk);
    chk("t1_done_pulse", {31'b0, frame_done}, 32'd0);
    chk("t1_done_cnt", done_cnt, 32'd1);

    rd(4'd0, 16'd0, 16'd0);
    rd(4'd5, 16'd5, 16'hFFFB);
    rd(4'd15, 16'd15, 16'hFFF1);
    rd_end();
    repeat (2) @(negedge clk);
    chk("t3_sb_empty", sbq.size(), 32'd0);
    chk("t3_rdv_off", {31'b0, rd_valid}, 32'd0);

    // overrun while FULL, then release to IDLE
    @(negedge clk);
    dma_valid = 1'b1;
    @(negedge clk);
    dma_valid = 1'b0;
    chk("t4_ovr", {31'b0, overrun}, 32'd1);
    release_frame(1'b0);
    chk("t4_ready_off", {31'b0, frame_ready}, 32'd0);
    chk("t4_cnt_clr", {27'b0, sample_count}, 32'd0);
    chk("t4_ack_idle", {31'b0, dma_ack}, 32'd0);
    @(negedge clk);
    chk("t4_ovr_sticky", {31'b0, overrun}, 32'd1);
    chk("t4_ack_idle2", {31'b0, dma_ack}, 32'd0);

    // frame 2: gaps, ignored release and capture drop mid-frame
    capture_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      send(16'(k + 100), 16'(k * 3));
      if (k % 2 == 0) begin
        @(negedge clk);
        dma_valid     = 1'b0;
        frame_release = (k == 4);
        if (k == 8) capture_en = 1'b0;
        if (k == 6) chk("t2_cnt_mid", {27'b0, sample_count}, 32'd7);
      end
    end
    @(negedge clk);
    dma_valid     = 1'b0;
    frame_release = 1'b0;
    chk("t2_done", {31'b0, frame_done}, 32'd1);
    chk("t2_cnt", {27'b0, sample_count}, 32'd16);
    chk("t2_fcnt", {24'b0, frame_count}, 32'd2);
    for (int k = 0; k < 16; k++) rd(4'(k), 16'(k + 100), 16'(k * 3));
    rd_end();
    release_frame(1'b1);
    chk("t2_rearm_ack", {31'b0, dma_ack}, 32'd1);
    chk("t2_rearm_ready", {31'b0, frame_ready}, 32'd0);

    // reset mid-frame discards partial frame
    for (int k = 0; k < 7; k++) send(16'(k + 50), 16'(k + 60));
    @(negedge clk);
    dma_valid = 1'b0;
    chk("t5_cnt7", {27'b0, sample_count}, 32'd7);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_cnt0", {27'b0, sample_count}, 32'd0);
    chk("t5_fcnt0", {24'b0, frame_count}, 32'd0);
    chk("t5_ack0", {31'b0, dma_ack}, 32'd0);
    chk("t5_ovr0", {31'b0, overrun}, 32'd0);
    chk("t5_rd0", {rd_real, rd_imag}, 32'd0);
    @(negedge clk);
    reset      = 1'b1;
    capture_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      v = 16'(-(k + 200));
      send(16'(k + 200), v);
    end
    @(negedge clk);
    dma_valid = 1'b0;
    chk("t5_fcnt1", {24'b0, frame_count}, 32'd1);
    chk("t5_ready", {31'b0, frame_ready}, 32'd1);
    rd(4'd0, 16'd200, 16'hFF38);
    rd(4'd6, 16'd206, 16'hFF32);
    rd(4'd15, 16'd215, 16'hFF29);
    rd_end();

`ifdef DMA_RX_CHECKSUM_EN
    release_frame(1'b1);
    for (int k = 0; k < 16; k++) send(16'(k), 16'd0);
    @(negedge clk);
    dma_valid = 1'b0;
    chk("t6_csum0", {16'b0, frame_checksum}, 32'h0000);
    release_frame(1'b1);
    for (int k = 0; k < 16; k++) send((k == 3) ? 16'h00FF : 16'h0, 16'h0);
    @(negedge clk);
    dma_valid = 1'b0;
    chk("t6_csum_ff", {16'b0, frame_checksum}, 32'h00FF);
`endif

    repeat (3) @(negedge clk);
    chk("end_sb_empty", sbq.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
